// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and presents one instruction per completed fetch.
// A branch that lands while the memory is busy is parked until the in-flight read finishes.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_read,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_busywait,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid
);

  typedef enum logic {FETCH, REDIR_PEND} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] pending_reg;
  logic [31:0] target_aligned;

  assign target_aligned = branch_target & ~32'h3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      pending_reg <= 32'h0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (branch_taken) begin
            if (imem_busywait) begin
              // The outstanding read cannot be aborted, so hold the address and park the target.
              pending_reg <= target_aligned;
              state_reg   <= REDIR_PEND;
            end else begin
              pc_reg <= target_aligned;
            end
          end else if (!imem_busywait && !stall) begin
            pc_reg <= pc_reg + 32'd4;
          end
        end
        REDIR_PEND: begin
          if (branch_taken) begin
            pending_reg <= target_aligned;
          end
          if (!imem_busywait) begin
            pc_reg    <= branch_taken ? target_aligned : pending_reg;
            state_reg <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  // Read data is forwarded combinationally; any cycle without a clean completion is a bubble.
  assign imem_read = reset;
  assign imem_addr = pc_reg;
  assign if_pc     = pc_reg;
  assign if_valid  = reset && (state_reg == FETCH) && !imem_busywait && !branch_taken;
  assign if_instr  = if_valid ? imem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against an abstract next-PC model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_busywait = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_read(imem_read), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_busywait(imem_busywait), .if_pc(if_pc),
    .if_instr(if_instr), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  // Reference: the address that will be fetched, plus whether a redirect is waiting for
  // the current read to drain and where it goes.
  logic [31:0] m_pc;
  logic        m_redirect_waiting;
  logic [31:0] m_redirect_to;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc               <= RESET_PC;
      m_redirect_waiting <= 1'b0;
      m_redirect_to      <= 32'h0;
    end else if (branch_taken) begin
      if (imem_busywait) begin
        m_redirect_waiting <= 1'b1;
        m_redirect_to      <= (branch_target / 4) * 4;
      end else begin
        m_redirect_waiting <= 1'b0;
        m_pc               <= (branch_target / 4) * 4;
      end
    end else if (m_redirect_waiting) begin
      if (!imem_busywait) begin
        m_redirect_waiting <= 1'b0;
        m_pc               <= m_redirect_to;
      end
    end else if (!imem_busywait && !stall) begin
      m_pc <= 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic exp_valid;
    exp_valid = reset && !m_redirect_waiting && !imem_busywait && !branch_taken;
    check_eq("imem_read", {31'b0, imem_read}, {31'b0, reset});
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_pc",     if_pc,     m_pc);
    check_eq("if_valid",  {31'b0, if_valid}, {31'b0, exp_valid});
    check_eq("if_instr",  if_instr,  exp_valid ? imem_rdata : NOP_INSTR);
  endtask

  // One transaction: called at a negedge, drives inputs, checks, and returns at the next negedge.
  task automatic step(input logic s, input logic b, input logic [31:0] t,
                      input logic bw, input logic [31:0] rd);
    stall = s; branch_taken = b; branch_target = t; imem_busywait = bw; imem_rdata = rd;
    #1;
    check_outputs();
    $display("cyc %0d rst=%b stall=%b br=%b tgt=%h busy=%b | addr=%h valid=%b instr=%h",
             cyc, reset, s, b, t, bw, imem_addr, if_valid, if_instr);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must react before any clock edge.
  task automatic mid_cycle_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_read",  {31'b0, imem_read}, 32'h0);
    check_eq("rst_pc",    if_pc,    RESET_PC);
    check_eq("rst_instr", if_instr, NOP_INSTR);
    check_eq("rst_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'hDEAD_0000);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h1111_1111);
    step(1'b0, 1'b1, 32'h44, 1'b1, 32'h2222_2222);
    reset = 1'b1;

    // Sequential fetch after reset release
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'hAAAA_0001);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'hBBBB_0002);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'hCCCC_0003);
    check_eq("seq_addr", imem_addr, 32'h0C);

    // Busywait hold at 0x10
    step(1'b0, 1'b1, 32'h10, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    check_eq("busy_addr", imem_addr, 32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h1000_0010);
    check_eq("busy_next", imem_addr, 32'h14);

    // Stall at 0x20, then branch under stall
    step(1'b0, 1'b1, 32'h20, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h2000_0020);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h2000_0020);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h2000_0020);
    check_eq("stall_next", imem_addr, 32'h24);
    step(1'b1, 1'b1, 32'h80, 1'b0, 32'h2000_0024);
    check_eq("br_over_stall", imem_addr, 32'h80);

    // Branch parked behind a busy read
    step(1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h103, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h4000_0040);
    check_eq("pend_target", imem_addr, 32'h100);

    // Newer branch overrides a parked one
    step(1'b0, 1'b1, 32'h300, 1'b1, 32'h0);
    step(1'b0, 1'b1, 32'h405, 1'b0, 32'h0);
    check_eq("pend_override", imem_addr, 32'h404);

    // Wrap-around
    step(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFF_0000);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset while a redirect is parked
    step(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    mid_cycle_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h7777_0000);
    check_eq("rst_discard", imem_addr, RESET_PC + 32'd4);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) mid_cycle_reset();
      step($urandom_range(99) < 20, $urandom_range(99) < 12, $urandom,
           $urandom_range(99) < 30, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
